// File: rtl/mul_div_scheduler_if.sv
// Signal bundle between the mul/div scheduler, its reservation stations,
// the shared multiplier/divider and the CDB arbiter.
interface mul_div_scheduler_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3
) ();
    logic                        flush;
    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            req_is_div;
    logic [N_REQ*DATA_WIDTH-1:0] req_vj;
    logic [N_REQ*DATA_WIDTH-1:0] req_vk;
    logic [N_REQ*TAG_WIDTH-1:0]  req_tag;
    logic [N_REQ-1:0]            grant;
    logic [DATA_WIDTH-1:0]       unit_a;
    logic [DATA_WIDTH-1:0]       unit_b;
    logic                        unit_clken;
    logic                        unit_aclr;
    logic [DATA_WIDTH-1:0]       mul_result;
    logic [DATA_WIDTH-1:0]       div_result;
    logic                        cdb_req;
    logic                        cdb_gnt;
    logic [DATA_WIDTH-1:0]       cdb_data;
    logic [TAG_WIDTH-1:0]        cdb_tag;
    logic                        cdb_valid;
    logic                        busy;

    modport slave (
        input  flush, req, req_is_div, req_vj, req_vk, req_tag,
        input  mul_result, div_result, cdb_gnt,
        output grant, unit_a, unit_b, unit_clken, unit_aclr,
        output cdb_req, cdb_data, cdb_tag, cdb_valid, busy
    );

    modport master (
        output flush, req, req_is_div, req_vj, req_vk, req_tag,
        output mul_result, div_result, cdb_gnt,
        input  grant, unit_a, unit_b, unit_clken, unit_aclr,
        input  cdb_req, cdb_data, cdb_tag, cdb_valid, busy
    );
endinterface

// File: rtl/mul_div_scheduler.sv
// Round-robin scheduler sharing one multiplier/divider pair among N_REQ
// reservation stations; holds each result until the CDB arbiter takes it.
//
// state    | meaning
// IDLE     | waiting for a station request, grant pulses combinationally
// RUN      | unit clocked, counting the fixed mul/div latency
// WAIT_CDB | result held on the CDB request port until granted
module mul_div_scheduler #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    mul_div_scheduler_if.slave  bus
);
    localparam int PTR_W   = $clog2(N_REQ);
    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_CDB} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  is_div_q, is_div_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;

    logic                  found;
    logic [PTR_W-1:0]      win;
    logic [PTR_W-1:0]      scan_idx;
    logic [DATA_WIDTH-1:0] sel_vj, sel_vk;
    logic [TAG_WIDTH-1:0]  sel_tag;
    logic                  sel_div;
    logic [N_REQ-1:0]      grant_c;
    logic [CNT_W-1:0]      lat_m1;
    logic                  cdb_req_c;

    // First requester strictly after the last winner, wrapping around.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + i) % N_REQ);
            if (!found && bus.req[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_vj  = '0;
        sel_vk  = '0;
        sel_tag = '0;
        sel_div = 1'b0;
        grant_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PTR_W'(i)) begin
                sel_vj  = bus.req_vj[i*DATA_WIDTH +: DATA_WIDTH];
                sel_vk  = bus.req_vk[i*DATA_WIDTH +: DATA_WIDTH];
                sel_tag = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                sel_div = bus.req_is_div[i];
                // rst_n term keeps grant low while reset is held with requests pending.
                grant_c[i] = rst_n && (state_q == IDLE) && !bus.flush && found;
            end
        end
    end

    assign lat_m1 = is_div_q ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        is_div_d = is_div_q;
        res_d    = res_q;
        case (state_q)
            IDLE: begin
                if (!bus.flush && found) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    rr_ptr_d = win;
                    a_d      = sel_vj;
                    b_d      = sel_vk;
                    tag_d    = sel_tag;
                    is_div_d = sel_div;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == lat_m1 && !bus.flush) begin
                    res_d   = is_div_q ? bus.div_result : bus.mul_result;
                    state_d = WAIT_CDB;
                end
            end
            WAIT_CDB: begin
                if (bus.cdb_gnt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= PTR_W'(N_REQ - 1);
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            is_div_q <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tag_q    <= tag_d;
            is_div_q <= is_div_d;
            res_q    <= res_d;
        end
    end

    // A flush suppresses the pending broadcast even if the arbiter grants.
    assign cdb_req_c      = (state_q == WAIT_CDB) && !bus.flush;
    assign bus.cdb_req    = cdb_req_c;
    assign bus.cdb_valid  = cdb_req_c && bus.cdb_gnt;
    assign bus.cdb_data   = res_q;
    assign bus.cdb_tag    = tag_q;
    assign bus.grant      = grant_c;
    assign bus.unit_a     = a_q;
    assign bus.unit_b     = b_q;
    assign bus.unit_clken = (state_q == RUN);
    assign bus.unit_aclr  = bus.flush;
    assign bus.busy       = (state_q != IDLE);
endmodule
